mem_access_unit: RTL and testbench

//  Per-SIC front end for the lock-arbitrated data memory. Accepts one load/store from the SIC

---
 rtl/mem_access_unit_pkg.sv | 30 +++
 rtl/mem_access_unit.sv | 127 ++++++++++++
 tb/tb_mem_access_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types for the lock-arbitrated data memory front end.
// Lock and memory request bundles plus the access FSM states.
package mem_access_unit_pkg;

  localparam int RPL_ID_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BACKOFF,
    S_RESP
  } mac_state_e;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // id is sized for the widest pool; narrower ports zero-extend
  typedef struct packed {
    logic                req;
    logic [RPL_ID_W-1:0] id;
  } rpl_req_t;

  function automatic logic is_aligned(input logic [31:0] a);
    return a[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Per-port load/store front end: requests the memory lock,
// drives the access while granted and returns a one-cycle response.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ID_WIDTH = 4,
  parameter int PORT_ID  = 0,
  parameter int TIMEOUT  = 15,
  parameter int BACKOFF  = 2,
  parameter int RETRY_W  = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_wen,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  output logic               resp_err,
  output rpl_req_t           rpl_out,
  output mem_req_t           mem_out,
  input  logic               grant,
  input  logic [31:0]        rdata,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int CNT_MAX = (TIMEOUT > BACKOFF) ? TIMEOUT : BACKOFF;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BO_LAST = CNT_W'(BACKOFF - 1);

  localparam logic [ID_WIDTH-1:0] ID_VAL = ID_WIDTH'(PORT_ID);
  localparam logic [RPL_ID_W-1:0] MY_ID  = RPL_ID_W'(ID_VAL);

  mac_state_e         state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  mem_req_t           op, op_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [RETRY_W-1:0] retry_q, retry_d;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    op_d    = op;
    rdata_d = rdata_q;
    err_d   = err_q;
    retry_d = retry_q;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          op_d  = '{wen: req_wen, addr: req_addr, wdata: req_wdata};
          cnt_d = '0;
          if (is_aligned(req_addr)) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      S_WAIT: begin
        if (grant) begin
          rdata_d = op.wen ? 32'd0 : rdata;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt == TO_LAST) begin
          state_d = S_BACKOFF;
          cnt_d   = '0;
          if (retry_q != '1) retry_d = retry_q + 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_BACKOFF: begin
        if (cnt == BO_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op      <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      retry_q <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      op      <= op_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      retry_q <= retry_d;
    end
  end

  // ready is gated by reset so it drops the instant reset asserts
  assign req_ready  = (state == S_IDLE) && !reset;
  assign resp_valid = (state == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign retry_cnt  = retry_q;

  always_comb begin
    rpl_out = '0;
    mem_out = '0;
    if (state == S_WAIT) begin
      rpl_out.req = 1'b1;
      rpl_out.id  = MY_ID;
      mem_out     = op;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Two front ends sharing a lock-arbitrated memory model;
// directed steps with a response scoreboard per port.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        v0, v1, wen0, wen1;
  logic [31:0] a0, a1, d0, d1;
  logic        ready0, ready1, rv0, rv1, err0, err1;
  logic [31:0] rr0, rr1, rd0, rd1;
  rpl_req_t    rpl0, rpl1;
  mem_req_t    m0, m1;
  logic        g0, g1;
  logic [7:0]  rc0, rc1;
  logic        block;

  logic [31:0] mem [0:63];

  int checks = 0;
  int failures = 0;
  int wen_cyc0 = 0;
  int req_cyc0 = 0;
  int resp_cnt0 = 0;

  exp_t q0[$];
  exp_t q1[$];

  mem_access_unit #(.PORT_ID(0)) u0 (
    .clock(clk), .reset(rst),
    .req_valid(v0), .req_ready(ready0),
    .req_wen(wen0), .req_addr(a0), .req_wdata(d0),
    .resp_valid(rv0), .resp_rdata(rr0), .resp_err(err0),
    .rpl_out(rpl0), .mem_out(m0),
    .grant(g0), .rdata(rd0), .retry_cnt(rc0)
  );

  mem_access_unit #(.PORT_ID(1)) u1 (
    .clock(clk), .reset(rst),
    .req_valid(v1), .req_ready(ready1),
    .req_wen(wen1), .req_addr(a1), .req_wdata(d1),
    .resp_valid(rv1), .resp_rdata(rr1), .resp_err(err1),
    .rpl_out(rpl1), .mem_out(m1),
    .grant(g1), .rdata(rd1), .retry_cnt(rc1)
  );

  // fixed-priority lock: one grant per cycle
  assign g0 = !block && rpl0.req;
  assign g1 = !block && rpl1.req && !g0;
  assign rd0 = g0 ? mem[m0.addr[7:2]] : 32'hBAD0BAD0;
  assign rd1 = g1 ? mem[m1.addr[7:2]] : 32'hBAD0BAD0;

  always @(posedge clk) begin
    if (g0 && m0.wen) mem[m0.addr[7:2]] <= m0.wdata;
    if (g1 && m1.wen) mem[m1.addr[7:2]] <= m1.wdata;
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (m0.wen) wen_cyc0++;
    if (rpl0.req) req_cyc0++;
    if (rv0) begin
      resp_cnt0++;
      if (q0.size() == 0) begin
        check("stray_resp0", 1, 0);
      end else begin
        e = q0.pop_front();
        check("rdata0", rr0, e.rdata);
        check("err0", err0, e.err);
      end
    end
    if (rv1) begin
      if (q1.size() == 0) begin
        check("stray_resp1", 1, 0);
      end else begin
        e = q1.pop_front();
        check("rdata1", rr1, e.rdata);
        check("err1", err1, e.err);
      end
    end
  end

  task automatic issue0(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input exp_t e);
    int n = 0;
    @(negedge clk);
    while (!ready0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("ready0", ready0, 1);
    v0 = 1'b1; wen0 = w; a0 = a; d0 = d;
    q0.push_back(e);
    @(posedge clk);
    #1 v0 = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("resp_timeout", (q0.size() + q1.size()), 0);
    @(negedge clk);
  endtask

  initial begin
    int low;
    int falls;
    int base;
    logic prev;
    rst = 1'b1; block = 1'b0;
    v0 = 0; v1 = 0; wen0 = 0; wen1 = 0;
    a0 = 0; a1 = 0; d0 = 0; d1 = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000 + i;
    mem[4]  = 32'hDEADBEEF;
    mem[16] = 32'h16161616;
    mem[17] = 32'h17171717;
    mem[20] = 32'h20202020;
    #1;
    check("rst_ready", ready0, 0);
    check("rst_resp", {rv0, rr0, err0}, 0);
    check("rst_rpl", rpl0, 0);
    check("rst_mem", m0, 0);
    check("rst_retry", rc0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("idle_ready", ready0, 1);

    // load with immediate grant
    issue0(1'b0, 32'h10, 0, '{32'hDEADBEEF, 1'b0});
    @(negedge clk);
    check("wait_req", rpl0.req, 1);
    check("wait_id", rpl0.id, 0);
    check("wait_no_resp", rv0, 0);
    @(negedge clk);
    check("resp_lat", rv0, 1);
    check("resp_unlock", rpl0.req, 0);
    wait_done();

    // store then load back
    base = wen_cyc0;
    issue0(1'b1, 32'h20, 32'hA5A50001, '{32'h0, 1'b0});
    wait_done();
    check("store_wen_cycles", wen_cyc0 - base, 1);
    check("store_mem", mem[8], 32'hA5A50001);
    issue0(1'b0, 32'h20, 0, '{32'hA5A50001, 1'b0});
    wait_done();

    // misaligned: error, no lock
    base = req_cyc0;
    issue0(1'b1, 32'h13, 32'h55555555, '{32'h0, 1'b1});
    @(negedge clk);
    check("mis_resp_lat", rv0, 1);
    wait_done();
    check("mis_no_req", req_cyc0 - base, 0);
    check("mis_mem", mem[4], 32'hDEADBEEF);

    // grant withheld: timeout and backoff
    block = 1'b1;
    issue0(1'b0, 32'h50, 0, '{32'h20202020, 1'b0});
    low = 0; falls = 0; prev = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!rpl0.req) low++;
      if (prev && !rpl0.req) falls++;
      prev = rpl0.req;
    end
    check("backoff_low", low, 4);
    check("backoff_drops", falls, 2);
    check("retry_cnt", rc0, 2);
    check("still_req", rpl0.req, 1);
    block = 1'b0;
    wait_done();

    // two ports load in the same cycle
    @(negedge clk);
    v0 = 1; wen0 = 0; a0 = 32'h40;
    v1 = 1; wen1 = 0; a1 = 32'h44;
    q0.push_back('{32'h16161616, 1'b0});
    q1.push_back('{32'h17171717, 1'b0});
    @(posedge clk);
    #1 begin v0 = 0; v1 = 0; end
    @(negedge clk);
    check("dual_one_grant", {g0, g1}, 2'b10);
    wait_done();

    // reset while waiting for the lock
    block = 1'b1;
    issue0(1'b0, 32'h10, 0, '{32'hDEADBEEF, 1'b0});
    repeat (3) @(negedge clk);
    check("pre_rst_req", rpl0.req, 1);
    base = resp_cnt0;
    #2 rst = 1'b1;
    #1;
    check("async_req_drop", rpl0.req, 0);
    check("async_ready_drop", ready0, 0);
    q0.delete();
    @(negedge clk);
    rst = 1'b0;
    block = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_ready", ready0, 1);
    check("post_rst_retry", rc0, 0);
    check("post_rst_no_resp", resp_cnt0 - base, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
